demux_rr_scheduler: RTL and testbench

DEMUX_RR_SCHEDULER -- requirements
Module: demux_rr_scheduler

---
 rtl/demux_rr_scheduler.sv | 94 +++++++++
 tb/tb_demux_rr_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/demux_rr_scheduler.sv
// Single-word holding-register demux: routes each accepted word to one of four channels,
// chosen round-robin or directly from s_in. Optional DEMUX_RR_CNT_EN adds per-channel drain counters.
module demux_rr_scheduler #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] d,
   input  logic          d_valid,
   output logic          d_ready,
   input  logic          mode,
   input  logic [1:0]    s_in,
   output logic [DW-1:0] y0,
   output logic [DW-1:0] y1,
   output logic [DW-1:0] y2,
   output logic [DW-1:0] y3,
   output logic [3:0]    y_valid,
   input  logic [3:0]    y_ready,
   output logic          s0,
   output logic          s1,
   output logic          busy
`ifdef DEMUX_RR_CNT_EN
   ,
   output logic [7:0]    cnt0,
   output logic [7:0]    cnt1,
   output logic [7:0]    cnt2,
   output logic [7:0]    cnt3
`endif
);

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   logic          state;
   logic [DW-1:0] held;
   logic [1:0]    tgt;
   logic [1:0]    rr_ptr;
   logic          out_hs;
   logic          in_hs;

   // A drain frees the register in the same cycle, so a new word can follow back to back.
   assign out_hs  = (state == ST_FULL) && y_ready[tgt];
   assign d_ready = (state == ST_EMPTY) || out_hs;
   assign in_hs   = d_valid && d_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= ST_EMPTY;
         held   <= '0;
         tgt    <= 2'd0;
         rr_ptr <= 2'd0;
      end else if (in_hs) begin
         state <= ST_FULL;
         held  <= d;
         if (mode) begin
            tgt <= s_in;
         end else begin
            tgt    <= rr_ptr;
            rr_ptr <= rr_ptr + 2'd1;
         end
      end else if (out_hs) begin
         state <= ST_EMPTY;
      end
   end

   assign busy    = (state == ST_FULL);
   assign y_valid = busy ? (4'b0001 << tgt) : 4'b0000;
   assign y0      = (busy && tgt == 2'd0) ? held : '0;
   assign y1      = (busy && tgt == 2'd1) ? held : '0;
   assign y2      = (busy && tgt == 2'd2) ? held : '0;
   assign y3      = (busy && tgt == 2'd3) ? held : '0;
   assign s0      = tgt[0];
   assign s1      = tgt[1];

`ifdef DEMUX_RR_CNT_EN
   // Counters wrap naturally at 8 bits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt0 <= 8'd0;
         cnt1 <= 8'd0;
         cnt2 <= 8'd0;
         cnt3 <= 8'd0;
      end else if (out_hs) begin
         case (tgt)
            2'd0:    cnt0 <= cnt0 + 8'd1;
            2'd1:    cnt1 <= cnt1 + 8'd1;
            2'd2:    cnt2 <= cnt2 + 8'd1;
            default: cnt3 <= cnt3 + 8'd1;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed self-checking bench for demux_rr_scheduler; exercises counters when DEMUX_RR_CNT_EN is defined.
module tb_demux_rr_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] d;
   logic       d_valid;
   logic       d_ready;
   logic       mode;
   logic [1:0] s_in;
   logic [7:0] y0, y1, y2, y3;
   logic [3:0] y_valid;
   logic [3:0] y_ready;
   logic       s0, s1;
   logic       busy;
`ifdef DEMUX_RR_CNT_EN
   logic [7:0] cnt0, cnt1, cnt2, cnt3;
`endif

   int checks = 0;
   int errors = 0;

   demux_rr_scheduler #(.DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .d_ready(d_ready),
      .mode(mode), .s_in(s_in), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .y_valid(y_valid), .y_ready(y_ready), .s0(s0), .s1(s1), .busy(busy)
`ifdef DEMUX_RR_CNT_EN
      , .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rn, input logic m, input logic [1:0] s,
                                input logic [7:0] dat, input logic dv, input logic [3:0] yr);
      rst_n   = rn;
      mode    = m;
      s_in    = s;
      d       = dat;
      d_valid = dv;
      y_ready = yr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected channel data follows from the expected one-hot valid and the held word.
   task automatic checkState(input string tag, input logic [3:0] ev, input logic [7:0] word,
                             input logic eb, input logic edr, input logic [1:0] esel);
      checkOutput({tag, ".y_valid"}, {28'd0, y_valid}, {28'd0, ev});
      checkOutput({tag, ".y0"}, {24'd0, y0}, ev[0] ? {24'd0, word} : 32'd0);
      checkOutput({tag, ".y1"}, {24'd0, y1}, ev[1] ? {24'd0, word} : 32'd0);
      checkOutput({tag, ".y2"}, {24'd0, y2}, ev[2] ? {24'd0, word} : 32'd0);
      checkOutput({tag, ".y3"}, {24'd0, y3}, ev[3] ? {24'd0, word} : 32'd0);
      checkOutput({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
      checkOutput({tag, ".d_ready"}, {31'd0, d_ready}, {31'd0, edr});
      checkOutput({tag, ".sel"}, {30'd0, s1, s0}, {30'd0, esel});
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
      tick();
      checkState("reset", 4'b0000, 8'h00, 1'b0, 1'b1, 2'd0);

      // Round-robin streaming, one word per cycle
      applyStimulus(1'b1, 1'b0, 2'd0, 8'h11, 1'b1, 4'b1111);
      tick();
      checkState("rr0", 4'b0001, 8'h11, 1'b1, 1'b1, 2'd0);
      d = 8'h22;
      tick();
      checkState("rr1", 4'b0010, 8'h22, 1'b1, 1'b1, 2'd1);
      d = 8'h33;
      tick();
      checkState("rr2", 4'b0100, 8'h33, 1'b1, 1'b1, 2'd2);
      d = 8'h44;
      tick();
      checkState("rr3", 4'b1000, 8'h44, 1'b1, 1'b1, 2'd3);
      d = 8'h55;
      tick();
      checkState("rr_wrap", 4'b0001, 8'h55, 1'b1, 1'b1, 2'd0);
      d_valid = 1'b0;
      tick();
      checkState("rr_drain", 4'b0000, 8'h00, 1'b0, 1'b1, 2'd0);

      // Direct mode to ch2 with backpressure; competing input must not disturb the held word
      applyStimulus(1'b1, 1'b1, 2'd2, 8'hA5, 1'b1, 4'b0000);
      tick();
      checkState("hold1", 4'b0100, 8'hA5, 1'b1, 1'b0, 2'd2);
      d    = 8'hFF;
      s_in = 2'd1;
      tick();
      checkState("hold2", 4'b0100, 8'hA5, 1'b1, 1'b0, 2'd2);
      tick();
      checkState("hold3", 4'b0100, 8'hA5, 1'b1, 1'b0, 2'd2);
      applyStimulus(1'b1, 1'b1, 2'd1, 8'hFF, 1'b0, 4'b0100);
      #1;
      checkOutput("drain_ready", {31'd0, d_ready}, 32'd1);
      tick();
      checkState("drained", 4'b0000, 8'h00, 1'b0, 1'b1, 2'd2);

      // Non-target readies are ignored; then same-edge drain and reload
      applyStimulus(1'b1, 1'b1, 2'd1, 8'h3C, 1'b1, 4'b0000);
      tick();
      checkState("ch1_load", 4'b0010, 8'h3C, 1'b1, 1'b0, 2'd1);
      applyStimulus(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 4'b1101);
      tick();
      checkState("ch1_stable", 4'b0010, 8'h3C, 1'b1, 1'b0, 2'd1);
      applyStimulus(1'b1, 1'b1, 2'd3, 8'h77, 1'b1, 4'b1111);
      #1;
      checkOutput("reload_ready", {31'd0, d_ready}, 32'd1);
      tick();
      checkState("reload", 4'b1000, 8'h77, 1'b1, 1'b1, 2'd3);
      d_valid = 1'b0;
      tick();
      checkState("reload_drain", 4'b0000, 8'h00, 1'b0, 1'b1, 2'd3);

      // rr_ptr is 1 here (direct captures leave it alone); reset must clear it and the held word
      applyStimulus(1'b1, 1'b0, 2'd0, 8'h99, 1'b1, 4'b0000);
      tick();
      checkState("rr_resume", 4'b0010, 8'h99, 1'b1, 1'b0, 2'd1);
      applyStimulus(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 4'b0000);
      tick();
      checkState("mid_reset", 4'b0000, 8'h00, 1'b0, 1'b1, 2'd0);
      applyStimulus(1'b1, 1'b0, 2'd0, 8'hAB, 1'b1, 4'b1111);
      tick();
      checkState("post_reset_rr", 4'b0001, 8'hAB, 1'b1, 1'b1, 2'd0);
      d_valid = 1'b0;
      tick();
      checkState("post_reset_drain", 4'b0000, 8'h00, 1'b0, 1'b1, 2'd0);

`ifdef DEMUX_RR_CNT_EN
      applyStimulus(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 4'b1111);
      tick();
      checkOutput("cnt0_reset", {24'd0, cnt0}, 32'd0);
      applyStimulus(1'b1, 1'b1, 2'd0, 8'h00, 1'b1, 4'b1111);
      for (int i = 0; i < 257; i++) begin
         d = i[7:0];
         tick();
      end
      d_valid = 1'b0;
      tick();
      checkOutput("cnt0_wrap", {24'd0, cnt0}, 32'd1);
      checkOutput("cnt1", {24'd0, cnt1}, 32'd0);
      checkOutput("cnt2", {24'd0, cnt2}, 32'd0);
      checkOutput("cnt3", {24'd0, cnt3}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
